clkgate_ctrl: RTL and testbench

Enable controller that directly drives the `en` input of the PLIC clock-gate cell. It watches activity of the gated domain and asserts/deasserts the gate enable with an idle-hysteresis counter. On a wake request it reopens the clock, waits a settle window, then acknowledges the requester via a req/ack handshake. It runs on the free-running (ungated) clock.

---
 rtl/clkgate_ctrl.sv | 114 +++++++++++
 tb/tb_clkgate_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgate_ctrl.sv
// Enable controller for the clock-gate cell: idle-hysteresis gating, settle-delayed wake and a
// one-shot req/ack handshake. Runs on the free-running clock.
module clkgate_ctrl #(
  parameter int unsigned IDLE_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         =
    $clog2(((IDLE_CYCLES > SETTLE_CYCLES) ? IDLE_CYCLES : SETTLE_CYCLES) + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic wake_req,
  input  logic force_on,
  input  logic test_mode,
  output logic cg_en,
  output logic wake_ack,
  output logic gated
);

  if (IDLE_CYCLES == 0) begin : gen_idle_check
    $error("clkgate_ctrl: IDLE_CYCLES must be at least 1");
  end

  localparam logic [CNT_W-1:0] IdleLast   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StRun, StGated, StWake} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  idle_cnt_q;
  logic [CNT_W-1:0]  settle_cnt_q;
  logic              ack_done_q;
  logic              cg_en_q;
  logic              wake_ack_q;
  logic              gated_q;

  logic act;
  logic ack_fire;

  assign act      = busy | wake_req | force_on;
  // test_mode pins the FSM in RUN, so it also qualifies the ack like RUN does.
  assign ack_fire = ((state_q == StRun) || test_mode) && wake_req && !ack_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      idle_cnt_q   <= '0;
      settle_cnt_q <= '0;
      ack_done_q   <= 1'b0;
      cg_en_q      <= 1'b1;
      wake_ack_q   <= 1'b0;
      gated_q      <= 1'b0;
    end else begin
      wake_ack_q <= ack_fire;
      // One ack per request level: re-arm only once wake_req has been seen low.
      if (!wake_req) begin
        ack_done_q <= 1'b0;
      end else if (ack_fire) begin
        ack_done_q <= 1'b1;
      end

      if (test_mode) begin
        state_q      <= StRun;
        idle_cnt_q   <= '0;
        settle_cnt_q <= '0;
        cg_en_q      <= 1'b1;
        gated_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StRun: begin
            if (act) begin
              idle_cnt_q <= '0;
            end else if (idle_cnt_q == IdleLast) begin
              state_q    <= StGated;
              idle_cnt_q <= '0;
              cg_en_q    <= 1'b0;
              gated_q    <= 1'b1;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
          StGated: begin
            // busy counts too: a frozen domain may be stuck with busy high.
            if (act) begin
              state_q      <= StWake;
              settle_cnt_q <= '0;
              cg_en_q      <= 1'b1;
              gated_q      <= 1'b0;
            end
          end
          StWake: begin
            if (settle_cnt_q == SettleLast) begin
              state_q    <= StRun;
              idle_cnt_q <= '0;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q    <= StRun;
            idle_cnt_q <= '0;
            cg_en_q    <= 1'b1;
            gated_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cg_en    = cg_en_q | test_mode;
  assign wake_ack = wake_ack_q;
  assign gated    = gated_q;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Self-checking bench for clkgate_ctrl: directed scenarios plus a randomized run, all compared
// against a behavioural model of idle/wake/ack rules.
module tb_clkgate_ctrl;

  localparam int IDLE   = 16;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, busy = 1'b0, wake_req = 1'b0, force_on = 1'b0, test_mode = 1'b0;
  logic cg_en, wake_ack, gated;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clkgate_ctrl #(
    .IDLE_CYCLES  (IDLE),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .wake_req (wake_req),
    .force_on (force_on),
    .test_mode(test_mode),
    .cg_en    (cg_en),
    .wake_ack (wake_ack),
    .gated    (gated)
  );

  // Model: gated flag, edges left until the domain counts as running again, consecutive idle
  // edges seen while running, and the request-level ack bookkeeping.
  bit m_gated = 0;
  int m_wake_left = 0;
  int m_idle = 0;
  bit m_acked = 0;
  bit m_ack = 0;

  task automatic model_step();
    bit act, running, fire;
    act = busy | wake_req | force_on;
    if (rst) begin
      m_gated = 0; m_wake_left = 0; m_idle = 0; m_acked = 0; m_ack = 0;
      return;
    end
    running = test_mode || (!m_gated && m_wake_left == 0);
    fire    = running && wake_req && !m_acked;
    m_acked = wake_req && (m_acked || fire);
    m_ack   = fire;
    if (test_mode) begin
      m_gated = 0; m_wake_left = 0; m_idle = 0;
    end else if (m_gated) begin
      if (act) begin
        m_gated = 0;
        m_wake_left = SETTLE + 1;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
    end else if (act) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == IDLE) begin
        m_gated = 1;
        m_idle = 0;
      end
    end
  endtask

  function automatic logic [2:0] model_out();
    return {(!m_gated) | test_mode, m_gated, m_ack};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic b, input logic w, input logic f, input logic t);
    busy = b; wake_req = w; force_on = f; test_mode = t;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    if ({cg_en, gated, wake_ack} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state: got %b want 100", {cg_en, gated, wake_ack});
    end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_idle_gating();
    int fall = -1;
    bit gated_ok = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ({cg_en, gated, wake_ack} !== model_out()) begin
        errors++;
        $display("FAIL idle_gating edge %0d: got %b want %b", i, {cg_en, gated, wake_ack},
                 model_out());
      end
      checks++;
      if (fall < 0 && cg_en === 1'b0) begin
        fall = i;
        gated_ok = (gated === 1'b1);
      end
    end
    if (fall !== IDLE || !gated_ok) begin
      errors++;
      $display("FAIL idle_gating_edge: cg_en fell at edge %0d gated=%0d, want edge %0d gated=1",
               fall, gated_ok, IDLE);
    end
    checks++;
  endtask

  task automatic test_wake_from_gated();
    int acks = 0;
    int ack_k = -1;
    drive(0, 1, 0, 0);
    tick();  // E0
    if ({cg_en, gated, wake_ack} !== 3'b100) begin
      errors++;
      $display("FAIL wake_e0: got %b want 100", {cg_en, gated, wake_ack});
    end
    checks++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if ({cg_en, gated, wake_ack} !== model_out()) begin
        errors++;
        $display("FAIL wake_hold k=%0d: got %b want %b", k, {cg_en, gated, wake_ack},
                 model_out());
      end
      checks++;
      if (wake_ack === 1'b1) begin
        acks++;
        if (ack_k < 0) ack_k = k;
      end
    end
    if (acks !== 1 || ack_k !== SETTLE + 2) begin
      errors++;
      $display("FAIL wake_ack_timing: %0d acks first at E0+%0d, want 1 at E0+%0d", acks, ack_k,
               SETTLE + 2);
    end
    checks++;
    wake_req = 1'b0;
    tick();
    wake_req = 1'b1;
    acks = 0;
    ack_k = -1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (wake_ack === 1'b1) begin
        acks++;
        if (ack_k < 0) ack_k = k;
      end
    end
    if (acks !== 1 || ack_k !== 1) begin
      errors++;
      $display("FAIL wake_reraise: %0d acks first at %0d, want 1 at 1", acks, ack_k);
    end
    checks++;
    wake_req = 1'b0;
    tick();
  endtask

  task automatic test_idle_restart();
    int fall = -1;
    do_reset();
    repeat (10) tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if ({cg_en, gated, wake_ack} !== model_out()) begin
        errors++;
        $display("FAIL idle_restart edge %0d: got %b want %b", i, {cg_en, gated, wake_ack},
                 model_out());
      end
      checks++;
      if (fall < 0 && cg_en === 1'b0) fall = i;
    end
    if (fall !== IDLE) begin
      errors++;
      $display("FAIL idle_restart_edge: fell %0d edges after busy, want %0d", fall, IDLE);
    end
    checks++;
  endtask

  task automatic test_wake_in_run();
    int acks = 0;
    int ack_k = -1;
    bit saw_gate = 0;
    do_reset();
    wake_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (wake_ack === 1'b1) begin
        acks++;
        if (ack_k < 0) ack_k = k;
      end
      if (gated !== 1'b0 || cg_en !== 1'b1) saw_gate = 1;
    end
    if (acks !== 1 || ack_k !== 1 || saw_gate) begin
      errors++;
      $display("FAIL wake_in_run: %0d acks first at %0d gated_seen=%0d, want 1 at 1 gated_seen=0",
               acks, ack_k, saw_gate);
    end
    checks++;
    wake_req = 1'b0;
    tick();
  endtask

  task automatic test_force_on();
    bit bad = 0;
    int fall = -1;
    do_reset();
    force_on = 1'b1;
    repeat (100) begin
      tick();
      if (cg_en !== 1'b1 || wake_ack !== 1'b0 || gated !== 1'b0) bad = 1;
    end
    if (bad) begin
      errors++;
      $display("FAIL force_on_hold: clock gated or ack seen while force_on, want neither");
    end
    checks++;
    force_on = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (fall < 0 && gated === 1'b1) fall = i;
    end
    if (fall !== IDLE) begin
      errors++;
      $display("FAIL force_on_release: gated after %0d edges, want %0d", fall, IDLE);
    end
    checks++;
  endtask

  task automatic test_test_mode();
    do_reset();
    repeat (IDLE) tick();
    if (gated !== 1'b1 || cg_en !== 1'b0) begin
      errors++;
      $display("FAIL tm_precond: gated=%b cg_en=%b, want 1 0", gated, cg_en);
    end
    checks++;
    test_mode = 1'b1;
    #1;
    if (cg_en !== 1'b1) begin
      errors++;
      $display("FAIL tm_comb: cg_en=%b want 1 before the edge", cg_en);
    end
    checks++;
    tick();
    if ({cg_en, gated, wake_ack} !== 3'b100) begin
      errors++;
      $display("FAIL tm_edge: got %b want 100", {cg_en, gated, wake_ack});
    end
    checks++;
    test_mode = 1'b0;
    tick();
    if ({cg_en, gated, wake_ack} !== 3'b100) begin
      errors++;
      $display("FAIL tm_release: got %b want 100 (running)", {cg_en, gated, wake_ack});
    end
    checks++;
  endtask

  task automatic test_reset_mid_wake();
    do_reset();
    repeat (IDLE) tick();
    wake_req = 1'b1;
    tick();  // into wake
    tick();
    rst = 1'b1;
    tick();
    if ({cg_en, gated, wake_ack} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_wake: got %b want 100", {cg_en, gated, wake_ack});
    end
    checks++;
    rst = 1'b0;
    tick();
    if ({cg_en, gated, wake_ack} !== model_out() || wake_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wake_ack: got %b want %b", {cg_en, gated, wake_ack}, model_out());
    end
    checks++;
    wake_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int dens = 0;
    bit ack_seen = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: dens = 0;
          1: dens = 5;
          default: dens = 50;
        endcase
      end
      busy = ($urandom_range(0, 99) < dens);
      if (wake_req && ack_seen) wake_req = 1'b0;
      else if (!wake_req && $urandom_range(0, 39) == 0) wake_req = 1'b1;
      force_on  = ($urandom_range(0, 199) == 0);
      test_mode = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
      ack_seen = (wake_ack === 1'b1);
      if ({cg_en, gated, wake_ack} !== model_out()) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", c, {cg_en, gated, wake_ack},
                 model_out());
      end
      checks++;
    end
    drive(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_gating();
    test_wake_from_gated();
    test_idle_restart();
    test_wake_in_run();
    test_force_on();
    test_test_mode();
    test_reset_mid_wake();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
